// File: rtl/guffin_vend_ctrl.sv
// Guffin vending controller: quarter-unit credit, priced dispense, timed change/refund ejection.
// Optional GUFFIN_COMBINED_CHANGE_EN: a credit of 3 in CHANGE ejects a half and a quarter together.
module guffin_vend_ctrl #(
   parameter int PRICE_Q      = 2,
   parameter int MAX_CREDIT_Q = 6,
   parameter int CREDIT_W     = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                coin_quarter,
   input  logic                coin_half,
   input  logic                cancel,
   output logic                guffin,
   output logic                quarter,
   output logic                halfDollar,
   output logic                reject_quarter,
   output logic                reject_half,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      VEND   = 2'd1,
      CHANGE = 2'd2
   } state_t;

   localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT_Q);
   localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE_Q);
   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_Q);
   localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);
   localparam logic [CREDIT_W-1:0] TWO_C   = CREDIT_W'(2);
   localparam logic [CREDIT_W-1:0] THREE_C = CREDIT_W'(3);

   state_t              state_reg, state_next;
   logic [CREDIT_W-1:0] credit_reg, credit_next;
   logic                rej_q_reg, rej_q_next;
   logic                rej_h_reg, rej_h_next;
   logic [CREDIT_W:0]   add;
   logic [CREDIT_W:0]   sum;
   logic [CREDIT_W:0]   new_credit;
   logic                combined_step;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ACCEPT;
         credit_reg <= '0;
         rej_q_reg  <= 1'b0;
         rej_h_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         credit_reg <= credit_next;
         rej_q_reg  <= rej_q_next;
         rej_h_reg  <= rej_h_next;
      end
   end

`ifdef GUFFIN_COMBINED_CHANGE_EN
   assign combined_step = (credit_reg == THREE_C);
`else
   assign combined_step = 1'b0;
`endif

   always_comb begin
      add        = '0;
      add[0]     = coin_quarter;
      add[1]     = coin_half;
      sum        = {1'b0, credit_reg} + add;
      new_credit = {1'b0, credit_reg};
      state_next  = state_reg;
      credit_next = credit_reg;
      rej_q_next  = 1'b0;
      rej_h_next  = 1'b0;
      guffin      = 1'b0;
      quarter     = 1'b0;
      halfDollar  = 1'b0;
      case (state_reg)
         ACCEPT: begin
            // All-or-nothing: an overflowing insertion bounces every coin of that cycle.
            if (sum <= MAX_W) begin
               new_credit = sum;
            end else begin
               rej_q_next = coin_quarter;
               rej_h_next = coin_half;
            end
            credit_next = new_credit[CREDIT_W-1:0];
            if (new_credit >= PRICE_W) begin
               state_next = VEND;
            end else if (cancel && (new_credit != '0)) begin
               state_next = CHANGE;
            end
         end
         VEND: begin
            guffin      = 1'b1;
            rej_q_next  = coin_quarter;
            rej_h_next  = coin_half;
            credit_next = credit_reg - PRICE_C;
            state_next  = (credit_reg == PRICE_C) ? ACCEPT : CHANGE;
         end
         CHANGE: begin
            rej_q_next = coin_quarter;
            rej_h_next = coin_half;
            if (combined_step) begin
               halfDollar  = 1'b1;
               quarter     = 1'b1;
               credit_next = '0;
            end else if (credit_reg >= TWO_C) begin
               halfDollar  = 1'b1;
               credit_next = credit_reg - TWO_C;
            end else if (credit_reg == ONE_C) begin
               quarter     = 1'b1;
               credit_next = '0;
            end else begin
               credit_next = '0;
            end
            if (credit_next == '0) begin
               state_next = ACCEPT;
            end
         end
         default: begin
            state_next  = ACCEPT;
            credit_next = '0;
         end
      endcase
   end

   assign credit         = credit_reg;
   assign busy           = (state_reg != ACCEPT);
   assign reject_quarter = rej_q_reg;
   assign reject_half    = rej_h_reg;

endmodule

// File: tb/tb_guffin_vend_ctrl.sv
// Randomized bench for guffin_vend_ctrl: three price points driven in parallel and checked
// against a per-cycle schedule model of dispense/change events.
module tb_guffin_vend_ctrl;

   localparam int N       = 3;
   localparam int MAX_C   = 6;
   localparam int CW      = 3;
   localparam int PRICES [N] = '{2, 4, 6};

   logic clk;
   logic rst_n;
   logic coin_quarter, coin_half, cancel;
   logic          g_o   [N];
   logic          q_o   [N];
   logic          h_o   [N];
   logic          rq_o  [N];
   logic          rh_o  [N];
   logic [CW-1:0] cr_o  [N];
   logic          b_o   [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_dut
         guffin_vend_ctrl #(
            .PRICE_Q      (PRICES[gi]),
            .MAX_CREDIT_Q (MAX_C),
            .CREDIT_W     (CW)
         ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .coin_quarter   (coin_quarter),
            .coin_half      (coin_half),
            .cancel         (cancel),
            .guffin         (g_o[gi]),
            .quarter        (q_o[gi]),
            .halfDollar     (h_o[gi]),
            .reject_quarter (rq_o[gi]),
            .reject_half    (rh_o[gi]),
            .credit         (cr_o[gi]),
            .busy           (b_o[gi])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: each pending busy cycle is one schedule entry describing what that cycle shows.
   typedef struct {
      bit g;
      bit hd;
      bit qt;
      int cr;
   } ent_t;

   ent_t sched [N][8];
   int   slen  [N];
   int   mcred [N];
   bit   erq   [N];
   bit   erh   [N];

   int n_checks;
   int n_errors;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int i, input bit g, input bit hd, input bit qt, input int cr);
      sched[i][slen[i]].g  = g;
      sched[i][slen[i]].hd = hd;
      sched[i][slen[i]].qt = qt;
      sched[i][slen[i]].cr = cr;
      slen[i]++;
   endtask

   task automatic push_change(input int i, input int r);
      int rem;
      rem = r;
`ifdef GUFFIN_COMBINED_CHANGE_EN
      if (rem == 3) begin
         push(i, 1'b0, 1'b1, 1'b1, 3);
         rem = 0;
      end
`endif
      while (rem >= 2) begin
         push(i, 1'b0, 1'b1, 1'b0, rem);
         rem -= 2;
      end
      if (rem == 1) push(i, 1'b0, 1'b0, 1'b1, 1);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         slen[i] = 0; mcred[i] = 0; erq[i] = 0; erh[i] = 0;
      end
   endtask

   task automatic model_step(input int i, input bit q, input bit h, input bit c);
      int sum;
      erq[i] = 1'b0;
      erh[i] = 1'b0;
      if (slen[i] > 0) begin
         for (int k = 0; k < 7; k++) sched[i][k] = sched[i][k+1];
         slen[i]--;
         erq[i] = q;
         erh[i] = h;
      end else begin
         sum = mcred[i] + int'(q) + 2 * int'(h);
         if (sum <= MAX_C) mcred[i] = sum;
         else begin
            erq[i] = q;
            erh[i] = h;
         end
         if (mcred[i] >= PRICES[i]) begin
            push(i, 1'b1, 1'b0, 1'b0, mcred[i]);
            push_change(i, mcred[i] - PRICES[i]);
            mcred[i] = 0;
         end else if (c && mcred[i] > 0) begin
            push_change(i, mcred[i]);
            mcred[i] = 0;
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < N; i++) begin
         bit busy_e;
         busy_e = (slen[i] > 0);
         chk($sformatf("p%0d_guffin", PRICES[i]),  int'(g_o[i]),  busy_e ? int'(sched[i][0].g)  : 0);
         chk($sformatf("p%0d_half", PRICES[i]),    int'(h_o[i]),  busy_e ? int'(sched[i][0].hd) : 0);
         chk($sformatf("p%0d_quarter", PRICES[i]), int'(q_o[i]),  busy_e ? int'(sched[i][0].qt) : 0);
         chk($sformatf("p%0d_credit", PRICES[i]),  int'(cr_o[i]), busy_e ? sched[i][0].cr : mcred[i]);
         chk($sformatf("p%0d_busy", PRICES[i]),    int'(b_o[i]),  int'(busy_e));
         chk($sformatf("p%0d_rej_q", PRICES[i]),   int'(rq_o[i]), int'(erq[i]));
         chk($sformatf("p%0d_rej_h", PRICES[i]),   int'(rh_o[i]), int'(erh[i]));
      end
   endtask

   task automatic run_cycle(input bit q, input bit h, input bit c, input bit do_rst);
      coin_quarter = q;
      coin_half    = h;
      cancel       = c;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) model_step(i, q, h, c);
      compare_all();
      $display("cyc q=%0b h=%0b c=%0b rst=%0b busy=%0b%0b%0b credit=%0d/%0d/%0d",
               q, h, c, do_rst, b_o[0], b_o[1], b_o[2], cr_o[0], cr_o[1], cr_o[2]);
      if (do_rst) begin
         rst_n = 1'b0;
         #1;
         model_reset();
         compare_all();
         #1;
         rst_n = 1'b1;
      end
   endtask

   // Directed preamble: q, h, cancel, reset-after-edge
   localparam int ND = 16;
   logic [3:0] dir_tbl [ND] = '{
      4'b0100, 4'b0000, 4'b1100, 4'b0001,   // half vend; q+h -> change, reset mid-CHANGE
      4'b0010, 4'b1000, 4'b0010, 4'b0000,   // cancel at 0; quarter then cancel
      4'b0100, 4'b0100, 4'b0100, 4'b1000,   // halves; coins while busy
      4'b1000, 4'b0100, 4'b1010, 4'b0000
   };

   initial begin
      logic [3:0] v;
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      coin_quarter = 1'b0;
      coin_half = 1'b0;
      cancel = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      for (int d = 0; d < ND; d++) begin
         v = dir_tbl[d];
         run_cycle(v[3], v[2], v[1], v[0]);
      end
      for (int n = 0; n < 3000; n++) begin
         run_cycle(($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 6) == 0,
                   ($urandom % 200) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
